// File: rtl/keycode_pkg.sv
// Shared types and decode for the keyboard command path: key classes,
// USB HID usage codes and the auto-repeat FSM state encoding.
package keycode_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        JUMP  = 3'd3,
        PAUSE = 3'd4
    } key_class_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } fsm_state_t;

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_P     = 8'h13;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_LEFT  = 8'h50;

    function automatic key_class_t decode_key(input logic [7:0] code);
        key_class_t cls;
        case (code)
            KC_A, KC_LEFT:  cls = LEFT;
            KC_D, KC_RIGHT: cls = RIGHT;
            KC_W, KC_SPACE: cls = JUMP;
            KC_P:           cls = PAUSE;
            default:        cls = NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/keycode_event_gen_if.sv
// Keycode-in / game-command-out bundle between the PIO side and the game logic.
interface keycode_event_gen_if;
    import keycode_pkg::*;

    logic [7:0] keycode;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       jump_req;
    logic       pause_req;
    key_class_t key_class;

    modport master (
        output keycode, frame_tick,
        input  move_left, move_right, jump_req, pause_req, key_class
    );

    modport slave (
        input  keycode, frame_tick,
        output move_left, move_right, jump_req, pause_req, key_class
    );

endinterface

// File: rtl/keycode_stable_filter.sv
// Accepts a keycode only after it has held the same value for FILT_LEN
// consecutive cycles; masks transients from multi-step software writes.
module keycode_stable_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    output logic [7:0] acc_code
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    logic [7:0]    last_code_p0;
    logic [CW-1:0] stable_cnt_p0;

    // Stage p0: stability tracking; cnt is the run length including this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_code_p0  <= 8'h00;
            stable_cnt_p0 <= '0;
            acc_code      <= 8'h00;
        end else if (keycode != last_code_p0) begin
            last_code_p0  <= keycode;
            stable_cnt_p0 <= CW'(1);
        end else if (stable_cnt_p0 == CW'(FILT_LEN - 1)) begin
            acc_code <= last_code_p0;
        end else begin
            stable_cnt_p0 <= stable_cnt_p0 + 1'b1;
        end
    end

endmodule

// File: rtl/keycode_event_gen.sv
// Keycode to frame-aligned game commands with press/auto-repeat generation.
// Optional input stability filter: define KEYCODE_STABLE_FILTER_EN.
module keycode_event_gen
    import keycode_pkg::*;
#(
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000,
    parameter int FILT_LEN     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    keycode_event_gen_if.slave  bus
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || FILT_LEN < 1) begin : g_bad_param
        $error("keycode_event_gen: REPEAT_DELAY, REPEAT_RATE and FILT_LEN must be >= 1");
    end

    logic [7:0]       acc_code;
    logic [7:0]       prev_code;
    key_class_t       cls;
    fsm_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_evt, rpt_evt;
    logic             jump_evt, pause_evt;
    logic             jump_stk, pause_stk;
    logic             move_left_p1, move_right_p1, jump_req_p1, pause_req_p1;

`ifdef KEYCODE_STABLE_FILTER_EN
    keycode_stable_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .keycode  (bus.keycode),
        .acc_code (acc_code)
    );
`else
    assign acc_code = bus.keycode;
`endif

    assign cls           = decode_key(acc_code);
    assign bus.key_class = cls;
    assign press_evt     = (acc_code != prev_code) && (cls != NONE);
    assign jump_evt      = (cls == JUMP) && (press_evt || rpt_evt);
    assign pause_evt     = (cls == PAUSE) && press_evt;

    // Stage p0: press detection and repeat timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            prev_code <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            prev_code <= acc_code;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rpt_evt   = 1'b0;
        if (cls == NONE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (press_evt) begin
            state_nxt = DELAY;
            cnt_nxt   = '0;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        rpt_evt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (cnt == RATE_LAST) begin
                        rpt_evt = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: frame alignment; an event on the tick cycle goes straight out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            move_left_p1  <= 1'b0;
            move_right_p1 <= 1'b0;
            jump_req_p1   <= 1'b0;
            pause_req_p1  <= 1'b0;
            jump_stk      <= 1'b0;
            pause_stk     <= 1'b0;
        end else if (bus.frame_tick) begin
            move_left_p1  <= (cls == LEFT);
            move_right_p1 <= (cls == RIGHT);
            jump_req_p1   <= jump_stk | jump_evt;
            pause_req_p1  <= pause_stk | pause_evt;
            jump_stk      <= 1'b0;
            pause_stk     <= 1'b0;
        end else begin
            jump_req_p1  <= 1'b0;
            pause_req_p1 <= 1'b0;
            if (jump_evt)  jump_stk  <= 1'b1;
            if (pause_evt) pause_stk <= 1'b1;
        end
    end

    assign bus.move_left  = move_left_p1;
    assign bus.move_right = move_right_p1;
    assign bus.jump_req   = jump_req_p1;
    assign bus.pause_req  = pause_req_p1;

endmodule

// File: tb/tb_keycode_event_gen.sv
// Bench for keycode_event_gen with REPEAT_DELAY=8, REPEAT_RATE=4, FILT_LEN=4.
module tb_keycode_event_gen;
    import keycode_pkg::*;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    keycode_event_gen_if bus();

    keycode_event_gen #(
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4),
        .FILT_LEN     (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic l;
        logic r;
        logic j;
        logic p;
    } exp_t;

    typedef struct {
        logic [7:0] kc;
        logic [2:0] cls;
        logic       l, r, j, p;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];
    exp_t sb_q[$];
    logic held_l = 1'b0;
    logic held_r = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs applied from a negedge, outputs checked at the next negedge.
    task automatic step(input logic [7:0] kc, input logic tk,
                        input logic el, input logic er, input logic ej, input logic ep);
        exp_t e;
        bus.keycode    = kc;
        bus.frame_tick = tk;
        if (tk) sb_q.push_back(exp_t'{el, er, ej, ep});
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            held_l = e.l;
            held_r = e.r;
        end else begin
            e = exp_t'{held_l, held_r, 1'b0, 1'b0};
        end
        check("move_left",  {7'd0, bus.move_left},  {7'd0, e.l});
        check("move_right", {7'd0, bus.move_right}, {7'd0, e.r});
        check("jump_req",   {7'd0, bus.jump_req},   {7'd0, e.j});
        check("pause_req",  {7'd0, bus.pause_req},  {7'd0, e.p});
        check("left_right_exclusive", {7'd0, bus.move_left & bus.move_right}, 8'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_left"},  {7'd0, bus.move_left},  8'd0);
        check({tag, "_right"}, {7'd0, bus.move_right}, 8'd0);
        check({tag, "_jump"},  {7'd0, bus.jump_req},   8'd0);
        check({tag, "_pause"}, {7'd0, bus.pause_req},  8'd0);
    endtask

    task automatic async_reset_pulse();
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        held_l = 1'b0;
        held_r = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h04, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h50, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h4F, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h1A, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h2C, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h13, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h05, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'hFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset_n        = 1'b0;
        bus.keycode    = 8'h00;
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_key_class", bus.key_class, 8'd0);
        reset_n = 1'b1;

`ifndef KEYCODE_STABLE_FILTER_EN
        // Decode table: each key pressed on a tick cycle, result visible next cycle
        for (int i = 0; i < NV; i++) begin
            step(8'h00, 1'b0, 0, 0, 0, 0);
            step(8'h00, 1'b0, 0, 0, 0, 0);
            bus.keycode    = vecs[i].kc;
            bus.frame_tick = 1'b1;
            #1 check("key_class", bus.key_class, vecs[i].cls);
            step(vecs[i].kc, 1'b1, vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].p);
        end

        // Short jump press latched until a much later tick, then cleared
        repeat (3) step(8'h2C, 1'b0, 0, 0, 0, 0);
        repeat (9) step(8'h00, 1'b0, 0, 0, 0, 0);
        step(8'h00, 1'b1, 0, 0, 1, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // 20-cycle hold, single tick at the end: press + repeats collapse
        for (int i = 0; i < 20; i++) step(8'h2C, (i == 19), 0, 0, 1, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);
        repeat (2) step(8'h00, 1'b0, 0, 0, 0, 0);

        // Tick every 4 cycles: events at hold 0, 8, 12, 16 -> frame ending at 7 is empty
        for (int i = 0; i < 20; i++) step(8'h2C, (i % 4 == 3), 0, 0, (i != 7), 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // Left then right without release
        repeat (4) step(8'h04, 1'b0, 0, 0, 0, 0);
        step(8'h04, 1'b1, 1, 0, 0, 0);
        repeat (4) step(8'h07, 1'b0, 0, 0, 0, 0);
        step(8'h07, 1'b1, 0, 1, 0, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // W to Space without release restarts the repeat delay
        for (int i = 0; i < 6; i++)  step(8'h1A, (i == 5), 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(8'h2C, (i % 4 == 3), 0, 0, (i != 7), 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // Pause held 30 cycles, tick every 5: exactly one pause_req, no repeats
        for (int i = 0; i < 30; i++) step(8'h13, (i % 5 == 4), 0, 0, 0, (i == 4));
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // Press coincident with tick, following frame empty
        step(8'h00, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b1, 0, 0, 1, 0);
        repeat (3) step(8'h2C, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b1, 0, 0, 0, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // Back-to-back ticks
        step(8'h00, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b1, 0, 0, 1, 0);
        step(8'h2C, 1'b1, 0, 0, 0, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // Async reset mid-hold clears levels
        step(8'h04, 1'b1, 1, 0, 0, 0);
        step(8'h04, 1'b0, 1, 0, 0, 0);
        async_reset_pulse();
        step(8'h04, 1'b1, 1, 0, 0, 0);

        // Async reset mid-hold of jump: held key gives a fresh press after release
        step(8'h2C, 1'b1, 0, 0, 1, 0);
        step(8'h2C, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b0, 0, 0, 0, 0);
        async_reset_pulse();
        step(8'h2C, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b1, 0, 0, 1, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);
`else
        // Two-cycle glitch is filtered out
        repeat (3) step(8'h00, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b0, 0, 0, 0, 0);
        step(8'h2C, 1'b0, 0, 0, 0, 0);
        repeat (5) step(8'h00, 1'b0, 0, 0, 0, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);

        // Held code is accepted after 4 cycles; tick on that cycle catches the press
        for (int i = 0; i < 4; i++) begin
            bus.keycode    = 8'h2C;
            bus.frame_tick = (i == 3);
            #1 check("filt_class_early", bus.key_class, 8'd0);
            step(8'h2C, (i == 3), 0, 0, 0, 0);
        end
        bus.keycode    = 8'h2C;
        bus.frame_tick = 1'b1;
        #1 check("filt_class_accepted", bus.key_class, 8'd3);
        step(8'h2C, 1'b1, 0, 0, 1, 0);
        step(8'h00, 1'b1, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
